// File: rtl/rib_rr.sv
// rib_rr: NM-master to NS-slave interconnect over one registered transaction path,
// with round-robin or fixed-priority arbitration, wait states, decode error and timeout.
module rib_rr #(
    parameter int NM        = 4,
    parameter int NS        = 8,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int SEL_W     = 4,
    parameter int TIMEOUT   = 255,
    parameter int PRIO_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NM-1:0]    m_req_i,
    input  logic [NM-1:0]    m_we_i,
    input  logic [NM*AW-1:0] m_addr_i,
    input  logic [NM*DW-1:0] m_wdata_i,
    output logic [NM*DW-1:0] m_rdata_o,
    output logic [NM-1:0]    m_ack_o,
    output logic [NM-1:0]    m_err_o,
    output logic [NS-1:0]    s_req_o,
    output logic [NS-1:0]    s_we_o,
    output logic [AW-1:0]    s_addr_o,
    output logic [DW-1:0]    s_wdata_o,
    input  logic [NS*DW-1:0] s_rdata_i,
    input  logic [NS-1:0]    s_ack_i,
    output logic             hold_flag_o
);
    localparam int GW = (NM > 1) ? $clog2(NM) : 1;
    localparam logic [SEL_W:0] NS_L = (SEL_W + 1)'(NS);
    localparam logic [15:0] TO_L = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e           state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d, last_q, last_d, arb_idx;
    logic             we_q, we_d, err_q, err_d, arb_found, arb_ok, sel_ack;
    logic [AW-1:0]    addr_q, addr_d, arb_addr;
    logic [DW-1:0]    wdata_q, wdata_d, rdata_q, rdata_d, sel_rdata;
    logic [15:0]      cnt_q, cnt_d;
    logic [SEL_W-1:0] sel;
    logic [NS-1:0]    sel_oh;

    // Scan starts just after the last grant so every requester is served within NM turns
    always_comb begin
        int k;
        k = 0;
        arb_idx = '0;
        arb_found = 1'b0;
        for (int i = 0; i < NM; i++) begin
            k = (PRIO_MODE != 0) ? i : (int'(last_q) + 1 + i) % NM;
            if (!arb_found && m_req_i[GW'(k)]) begin
                arb_found = 1'b1;
                arb_idx = GW'(k);
            end
        end
    end

    assign arb_addr = m_addr_i[arb_idx*AW +: AW];
    assign arb_ok   = {1'b0, arb_addr[AW-1 -: SEL_W]} < NS_L;
    assign sel      = addr_q[AW-1 -: SEL_W];

    always_comb begin
        sel_oh = '0;
        sel_rdata = '0;
        for (int j = 0; j < NS; j++) begin
            sel_oh[j] = (sel == SEL_W'(j));
            sel_rdata = sel_rdata | (sel_oh[j] ? s_rdata_i[j*DW +: DW] : '0);
        end
    end

    assign sel_ack = |(s_ack_i & sel_oh);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q <= '0;
            last_q  <= GW'(NM - 1);
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            grant_q <= grant_d;
            last_q  <= last_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        we_d    = we_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (arb_found) begin
                grant_d = arb_idx;
                addr_d  = arb_addr;
                we_d    = m_we_i[arb_idx];
                wdata_d = m_wdata_i[arb_idx*DW +: DW];
                err_d   = !arb_ok;
                rdata_d = '0;
                cnt_d   = '0;
                state_d = arb_ok ? ACCESS : RESP;
            end
            ACCESS: begin
                cnt_d = cnt_q + 16'd1;
                // A slave ack in the timeout cycle still completes normally
                if (sel_ack) begin
                    rdata_d = we_q ? '0 : sel_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == TO_L) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                last_d  = grant_q;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_ack_o   = '0;
        m_err_o   = '0;
        m_rdata_o = '0;
        if (state_q == RESP) begin
            m_ack_o[grant_q] = 1'b1;
            m_err_o[grant_q] = err_q;
            m_rdata_o[grant_q*DW +: DW] = rdata_q;
        end
        s_req_o     = (state_q == ACCESS) ? sel_oh : '0;
        s_we_o      = (state_q == ACCESS && we_q) ? sel_oh : '0;
        s_addr_o    = (state_q == ACCESS) ? {{SEL_W{1'b0}}, addr_q[AW-SEL_W-1:0]} : '0;
        s_wdata_o   = (state_q == ACCESS) ? wdata_q : '0;
        hold_flag_o = (state_q != IDLE) || (|m_req_i);
    end
endmodule

// File: tb/tb_rib_rr.sv
// tb_rib_rr: directed and randomized checks of rib_rr against a transaction-level model.
module tb_rib_rr;
    localparam int NM = 4, NS = 8, AW = 32, DW = 32, SEL_W = 4, TO = 8;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic [NM-1:0]    m_req, m_we, m_ack, m_err, fp_ack, fp_err;
    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_wdata, m_rdata, fp_rdata;
    logic [NS-1:0]    s_req, s_we, s_ack, fp_sreq, fp_swe;
    logic [AW-1:0]    s_addr, fp_saddr;
    logic [DW-1:0]    s_wdata, fp_swdata;
    logic [NS*DW-1:0] s_rdata;
    logic             hold, fp_hold;

    rib_rr #(.NM(NM), .NS(NS), .AW(AW), .DW(DW), .SEL_W(SEL_W), .TIMEOUT(TO), .PRIO_MODE(0)) u_rr (
        .clk(clk), .rst(rst), .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
        .m_rdata_o(m_rdata), .m_ack_o(m_ack), .m_err_o(m_err), .s_req_o(s_req), .s_we_o(s_we),
        .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_rdata_i(s_rdata), .s_ack_i(s_ack), .hold_flag_o(hold));

    rib_rr #(.NM(NM), .NS(NS), .AW(AW), .DW(DW), .SEL_W(SEL_W), .TIMEOUT(TO), .PRIO_MODE(1)) u_fp (
        .clk(clk), .rst(rst), .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
        .m_rdata_o(fp_rdata), .m_ack_o(fp_ack), .m_err_o(fp_err), .s_req_o(fp_sreq), .s_we_o(fp_swe),
        .s_addr_o(fp_saddr), .s_wdata_o(fp_swdata), .s_rdata_i('0), .s_ack_i(fp_sreq), .hold_flag_o(fp_hold));

    // Slaves: ack once their request has been held for wt[k] cycles; data = sdat[k] ^ address
    int unsigned wt[NS];
    logic [DW-1:0] sdat[NS];
    int unsigned scnt[NS];

    always @(posedge clk)
        for (int k = 0; k < NS; k++) scnt[k] <= s_req[k] ? scnt[k] + 1 : 0;

    always_comb begin
        s_ack = '0;
        s_rdata = '0;
        for (int k = 0; k < NS; k++) begin
            s_ack[k] = s_req[k] && (scnt[k] >= wt[k]);
            s_rdata[k*DW +: DW] = sdat[k] ^ s_addr;
        end
    end

    int npass = 0, nchk = 0;
    int cyc, t0, lastg, g, sel, ack_at, fp_t0, drop_mode;
    bit busy, dec, exp_e, lwe, rnd, fp_chk;
    logic [AW-1:0] la;
    logic [DW-1:0] lwd, exp_d;
    int obs_m[$], obs_c[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic new_req(input int i);
        m_req[i] = 1'b1;
        m_we[i] = 1'($urandom);
        m_addr[i*AW +: AW] = {4'($urandom_range(9)), 28'($urandom)};
        m_wdata[i*DW +: DW] = $urandom;
    endtask

    // One cycle: compare outputs with the model, arbitrate in the model, then advance
    task automatic step();
        logic [NM-1:0] ea;
        logic [NM*DW-1:0] ed;
        logic [NS-1:0] es;
        bit acc, ackc, was_idle;
        @(negedge clk);
        ackc = busy && cyc == ack_at;
        acc = busy && !dec && cyc < ack_at;
        ea = ackc ? NM'(1) << g : '0;
        ed = '0;
        if (ackc) ed[g*DW +: DW] = exp_d;
        es = acc ? NS'(1) << sel : '0;
        chk("m_ack", m_ack, ea);
        chk("m_err", m_err, exp_e ? ea : '0);
        chk("m_rdata", m_rdata, ed);
        chk("s_req", s_req, es);
        chk("s_we", s_we, lwe ? es : '0);
        chk("s_addr", s_addr, acc ? {4'b0, la[27:0]} : 32'h0);
        chk("s_wdata", s_wdata, acc ? lwd : 32'h0);
        chk("hold", hold, busy || (|m_req));
        if (fp_chk) chk("fp_ack", fp_ack, ((cyc - fp_t0) % 3 == 2) ? 4'b0001 : 4'b0000);
        for (int i = 0; i < NM; i++) if (m_ack[i]) begin obs_m.push_back(i); obs_c.push_back(cyc); end
        was_idle = !busy;
        if (ackc) begin busy = 0; lastg = g; end
        if (was_idle && (|m_req)) begin
            for (int i = NM - 1; i >= 0; i--) if (m_req[(lastg + 1 + i) % NM]) g = (lastg + 1 + i) % NM;
            la = m_addr[g*AW +: AW];
            lwe = m_we[g];
            lwd = m_wdata[g*DW +: DW];
            sel = int'(la[31:28]);
            dec = sel >= NS;
            busy = 1;
            if (dec) begin
                ack_at = cyc + 1; exp_e = 1; exp_d = '0;
            end else if (wt[sel] < TO) begin
                ack_at = cyc + 2 + int'(wt[sel]); exp_e = 0;
                exp_d = lwe ? '0 : sdat[sel] ^ {4'b0, la[27:0]};
            end else begin
                ack_at = cyc + 1 + TO; exp_e = 1; exp_d = '0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (ackc && drop_mode == 1) m_req[g] = 1'b0;
        if (ackc && drop_mode == 2) begin
            if ($urandom_range(3) != 0) m_req[g] = 1'b0;
            else new_req(g);
        end
        if (rnd)
            for (int i = 0; i < NM; i++) begin
                if (!m_req[i] && $urandom_range(3) == 0) new_req(i);
                else if (m_req[i] && $urandom_range(7) == 0) m_addr[i*AW +: AW] = $urandom;
                else if (m_req[i] && $urandom_range(15) == 0) m_req[i] = 1'b0;
            end
    endtask

    initial begin
        m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
        for (int k = 0; k < NS; k++) begin wt[k] = 0; sdat[k] = '0; end
        busy = 0; dec = 0; exp_e = 0; lwe = 0; rnd = 0; fp_chk = 0; drop_mode = 0;
        lastg = NM - 1; g = 0; sel = 0; ack_at = 0; cyc = 0; la = '0; lwd = '0; exp_d = '0;
        #12;
        chk("rst_ack", m_ack, 4'h0);
        chk("rst_err", m_err, 4'h0);
        chk("rst_rdata", m_rdata, '0);
        chk("rst_sreq", s_req, 8'h0);
        chk("rst_swe", s_we, 8'h0);
        chk("rst_saddr", s_addr, 32'h0);
        chk("rst_swdata", s_wdata, 32'h0);
        chk("rst_hold", hold, 1'b0);
        chk("rst_fp_ack", fp_ack, 4'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) step();

        // Round-robin rotation; fixed-priority instance must grant master 0 every time
        obs_m.delete(); obs_c.delete();
        for (int i = 0; i < NM; i++) m_addr[i*AW +: AW] = 32'h100 + 32'(i * 16);
        m_req = 4'hF;
        t0 = cyc; fp_t0 = cyc; fp_chk = 1;
        repeat (15) step();
        fp_chk = 0;
        m_req = '0;
        chk("rr_n", 128'(obs_m.size()), 128'd5);
        for (int i = 0; i < 5; i++) begin
            chk("rr_m", (i < obs_m.size()) ? 128'(obs_m[i]) : '1, 128'(i % NM));
            chk("rr_c", (i < obs_c.size()) ? 128'(obs_c[i] - t0) : '1, 128'(2 + 3 * i));
        end
        repeat (3) step();

        // Single read, same-cycle slave ack
        drop_mode = 1;
        sdat[1] = 32'hDEADBEAF;
        m_addr[2*AW +: AW] = 32'h1000_0040; m_we[2] = 1'b0; m_req[2] = 1'b1;
        t0 = cyc;
        step();
        chk("t1_sreq", s_req, 8'h02);
        chk("t1_saddr", s_addr, 32'h0000_0040);
        step();
        chk("t1_ack", m_ack, 4'b0100);
        chk("t1_rdata", m_rdata[2*DW +: DW], 32'hDEADBEEF);
        chk("t1_err", m_err, 4'b0000);
        repeat (3) step();

        // Five wait states on slave 3
        obs_m.delete(); obs_c.delete();
        wt[3] = 5; sdat[3] = 32'h1234_5678;
        m_addr[1*AW +: AW] = 32'h3000_0010; m_we[1] = 1'b0; m_req[1] = 1'b1;
        t0 = cyc;
        repeat (10) step();
        chk("t3_wait_c", (obs_c.size() > 0) ? 128'(obs_c[0] - t0) : '1, 128'd7);

        // Never-acking slave times out; a slave acking in the timeout cycle still wins
        obs_m.delete(); obs_c.delete();
        wt[5] = 255;
        m_addr[3*AW +: AW] = 32'h5000_0000; m_we[3] = 1'b1; m_wdata[3*DW +: DW] = 32'hA5A5_A5A5; m_req[3] = 1'b1;
        t0 = cyc;
        repeat (12) step();
        chk("t3_to_c", (obs_c.size() > 0) ? 128'(obs_c[0] - t0) : '1, 128'(TO + 1));
        obs_m.delete(); obs_c.delete();
        wt[6] = TO - 1; sdat[6] = 32'hCAFE_F00D;
        m_addr[0*AW +: AW] = 32'h6000_0004; m_we[0] = 1'b0; m_req[0] = 1'b1;
        t0 = cyc;
        repeat (12) step();
        chk("t3_edge_c", (obs_c.size() > 0) ? 128'(obs_c[0] - t0) : '1, 128'(TO + 1));

        // Decode error: no slave touched
        obs_m.delete(); obs_c.delete();
        m_addr[0*AW +: AW] = 32'h9000_0000; m_we[0] = 1'b1; m_req[0] = 1'b1;
        t0 = cyc;
        repeat (4) step();
        chk("t4_m", (obs_m.size() > 0) ? 128'(obs_m[0]) : '1, 128'd0);
        chk("t4_c", (obs_c.size() > 0) ? 128'(obs_c[0] - t0) : '1, 128'd1);

        // Grant lock: master 1 withdraws and changes address during its access
        m_addr[1*AW +: AW] = 32'h2000_0080; m_we[1] = 1'b0; m_req[1] = 1'b1;
        step();
        m_req[1] = 1'b0; m_addr[1*AW +: AW] = 32'h2000_0FF0;
        #1;
        chk("t5_saddr", s_addr, 32'h0000_0080);
        step();
        chk("t5_ack", m_ack, 4'b0010);
        repeat (3) step();

        // Reset during ACCESS
        wt[4] = 3;
        for (int i = 0; i < NM; i++) m_addr[i*AW +: AW] = 32'h4000_0000 + 32'(i * 4);
        m_req[2] = 1'b1;
        step();
        chk("t6_sreq_pre", s_req, 8'h10);
        m_req = 4'hF;
        rst = 1'b1;
        #1;
        chk("t6_sreq_rst", s_req, 8'h00);
        chk("t6_ack_rst", m_ack, 4'h0);
        #1;
        rst = 1'b0;
        busy = 0; lastg = NM - 1;
        obs_m.delete(); obs_c.delete();
        repeat (6) step();
        chk("t6_first", (obs_m.size() > 0) ? 128'(obs_m[0]) : '1, 128'd0);
        m_req = '0;
        repeat (3) step();

        // Randomized traffic
        for (int k = 0; k < NS; k++) begin
            sdat[k] = $urandom;
            case ($urandom_range(5))
                0: wt[k] = 0;
                1: wt[k] = 1;
                2: wt[k] = 2;
                3: wt[k] = 3;
                4: wt[k] = TO - 1;
                default: wt[k] = 255;
            endcase
        end
        wt[0] = 0;
        drop_mode = 2; rnd = 1;
        repeat (3000) step();
        drop_mode = 1; rnd = 0;
        repeat (80) step();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
